// File: rtl/fp_operand_swap.sv
// Operand-ordering front stage of the FP adder: the larger-magnitude operand always leaves on slot 1.
// Define FP_SWAP_MANT_CMP_EN to break equal-exponent ties on the mantissa instead of keeping input order.
module fp_operand_swap #(
   parameter int MANT_W = 10,
   parameter int EXP_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [MANT_W-1:0] inp1,
   input  logic              sgn1,
   input  logic [EXP_W-1:0]  exp1,
   input  logic [MANT_W-1:0] inp2,
   input  logic              sgn2,
   input  logic [EXP_W-1:0]  exp2,
   output logic [MANT_W-1:0] outinp1,
   output logic              outsign1,
   output logic [EXP_W-1:0]  outexp1,
   output logic [MANT_W-1:0] outinp2,
   output logic              outsgn2,
   output logic [EXP_W-1:0]  outexp2,
   output logic [EXP_W-1:0]  exp_diff,
   output logic              swapped,
   output logic              out_valid
);

   logic             sw;
   logic [EXP_W-1:0] diff;

`ifdef FP_SWAP_MANT_CMP_EN
   assign sw = (exp2 > exp1) || ((exp2 == exp1) && (inp2 > inp1));
`else
   assign sw = (exp2 > exp1);
`endif

   // The larger exponent is always the minuend, so the subtraction cannot wrap.
   assign diff = sw ? (exp2 - exp1) : (exp1 - exp2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outinp1   <= '0;
         outsign1  <= 1'b0;
         outexp1   <= '0;
         outinp2   <= '0;
         outsgn2   <= 1'b0;
         outexp2   <= '0;
         exp_diff  <= '0;
         swapped   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            outinp1  <= sw ? inp2 : inp1;
            outsign1 <= sw ? sgn2 : sgn1;
            outexp1  <= sw ? exp2 : exp1;
            outinp2  <= sw ? inp1 : inp2;
            outsgn2  <= sw ? sgn1 : sgn2;
            outexp2  <= sw ? exp1 : exp2;
            exp_diff <= diff;
            swapped  <= sw;
         end
      end
   end

endmodule

// File: tb/tb_fp_operand_swap.sv
// Scoreboard bench for fp_operand_swap: stimulus pushes model results, a monitor pops them on out_valid.
// Honours FP_SWAP_MANT_CMP_EN the same way the design does.
module tb_fp_operand_swap;

   localparam int MANT_W = 10;
   localparam int EXP_W  = 5;

   typedef struct packed {
      logic [MANT_W-1:0] m1;
      logic              s1;
      logic [EXP_W-1:0]  e1;
      logic [MANT_W-1:0] m2;
      logic              s2;
      logic [EXP_W-1:0]  e2;
      logic [EXP_W-1:0]  diff;
      logic              sw;
   } result_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [MANT_W-1:0] inp1, inp2;
   logic              sgn1, sgn2;
   logic [EXP_W-1:0]  exp1, exp2;
   logic [MANT_W-1:0] outinp1, outinp2;
   logic              outsign1, outsgn2;
   logic [EXP_W-1:0]  outexp1, outexp2, exp_diff;
   logic              swapped, out_valid;

   int      checks = 0;
   int      errors = 0;
   result_t expq[$];
   result_t held = '0;
   logic    modelValid = 1'b0;

   fp_operand_swap #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .inp1(inp1), .sgn1(sgn1), .exp1(exp1),
      .inp2(inp2), .sgn2(sgn2), .exp2(exp2),
      .outinp1(outinp1), .outsign1(outsign1), .outexp1(outexp1),
      .outinp2(outinp2), .outsgn2(outsgn2), .outexp2(outexp2),
      .exp_diff(exp_diff), .swapped(swapped), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference: rank each operand by magnitude as a single number, the larger one goes to slot 1.
   function automatic result_t model(input int m1, input int s1, input int e1,
                                     input int m2, input int s2, input int e2);
      result_t r;
      int rank1, rank2;
      rank1 = e1 * 4096;
      rank2 = e2 * 4096;
`ifdef FP_SWAP_MANT_CMP_EN
      rank1 = rank1 + m1;
      rank2 = rank2 + m2;
`endif
      if (rank2 > rank1) begin
         r.m1 = m2[MANT_W-1:0]; r.s1 = s2[0]; r.e1 = e2[EXP_W-1:0];
         r.m2 = m1[MANT_W-1:0]; r.s2 = s1[0]; r.e2 = e1[EXP_W-1:0];
         r.diff = 5'(e2 - e1);
         r.sw = 1'b1;
      end else begin
         r.m1 = m1[MANT_W-1:0]; r.s1 = s1[0]; r.e1 = e1[EXP_W-1:0];
         r.m2 = m2[MANT_W-1:0]; r.s2 = s2[0]; r.e2 = e2[EXP_W-1:0];
         r.diff = 5'(e1 - e2);
         r.sw = 1'b0;
      end
      return r;
   endfunction

   task automatic compare(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input result_t e, input logic v);
      compare({tag, ".out_valid"}, int'(out_valid), int'(v));
      compare({tag, ".outinp1"},  int'(outinp1),  int'(e.m1));
      compare({tag, ".outsign1"}, int'(outsign1), int'(e.s1));
      compare({tag, ".outexp1"},  int'(outexp1),  int'(e.e1));
      compare({tag, ".outinp2"},  int'(outinp2),  int'(e.m2));
      compare({tag, ".outsgn2"},  int'(outsgn2),  int'(e.s2));
      compare({tag, ".outexp2"},  int'(outexp2),  int'(e.e2));
      compare({tag, ".exp_diff"}, int'(exp_diff), int'(e.diff));
      compare({tag, ".swapped"},  int'(swapped),  int'(e.sw));
   endtask

   // Drives one cycle of input on the falling edge and records the expected result.
   task automatic applyStimulus(input logic v, input int m1, input int s1, input int e1,
                                input int m2, input int s2, input int e2);
      @(negedge clk);
      in_valid = v;
      inp1 = m1[MANT_W-1:0]; sgn1 = s1[0]; exp1 = e1[EXP_W-1:0];
      inp2 = m2[MANT_W-1:0]; sgn2 = s2[0]; exp2 = e2[EXP_W-1:0];
      if (v) expq.push_back(model(m1, s1, e1, m2, s2, e2));
   endtask

   // Monitor: every cycle the outputs must equal the last popped result (or zero after reset).
   always @(posedge clk) begin
      logic iv, rv;
      iv = in_valid;
      rv = rst_n;
      #1;
      if (!rv) begin
         modelValid = 1'b0;
         held = '0;
      end else begin
         modelValid = iv;
         if (iv) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard_underflow actual=out_valid required=empty_queue at %0t", $time);
            end else begin
               held = expq.pop_front();
            end
         end
      end
      checkOutput("mon", held, modelValid);
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      inp1 = '0; sgn1 = 1'b0; exp1 = '0;
      inp2 = '0; sgn2 = 1'b0; exp2 = '0;
      #1;
      checkOutput("reset", '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases, including the equal-exponent tie in both operand orders.
      applyStimulus(1'b1, 0, 0, 17, 32, 0, 11);
      applyStimulus(1'b1, 484, 0, 9, 391, 0, 11);
      applyStimulus(1'b1, 7, 1, 5, 9, 0, 20);
      applyStimulus(1'b1, 3, 0, 11, 14, 0, 11);
      applyStimulus(1'b1, 14, 0, 11, 3, 0, 11);
      applyStimulus(1'b1, 5, 1, 11, 5, 0, 11);
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);

      // Back-to-back burst followed by idle cycles where outputs must hold.
      applyStimulus(1'b1, 897, 0, 29, 141, 1, 27);
      applyStimulus(1'b1, 1, 0, 0, 1023, 1, 31);
      applyStimulus(1'b1, 1023, 1, 31, 0, 0, 0);
      applyStimulus(1'b1, 512, 0, 16, 511, 0, 16);
      applyStimulus(1'b1, 100, 1, 3, 200, 1, 4);
      applyStimulus(1'b1, 600, 0, 30, 700, 1, 30);
      repeat (3) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);

      // Randomised traffic with frequent exponent ties.
      for (int i = 0; i < 300; i++) begin
         int e1, e2;
         e1 = int'($urandom_range(0, 31));
         e2 = ($urandom_range(0, 3) == 0) ? e1 : int'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)), e1,
                       int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)), e2);
      end

      // Asynchronous reset between edges while a result is showing and another pair is in flight.
      applyStimulus(1'b1, 40, 1, 22, 50, 0, 12);
      applyStimulus(1'b1, 60, 0, 8, 70, 1, 9);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      expq.delete();
      #1;
      checkOutput("async_reset", '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 9, 0, 2, 8, 1, 7);
      repeat (2) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);

      @(posedge clk);
      #2;
      compare("queue_drained", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fp_operand_swap.md
# fp_operand_swap

Operand-alignment front stage of the half-precision-style floating-point adder: accepts two operands (10-bit mantissa field, sign, 5-bit exponent) and emits them reordered so the larger-magnitude operand is always on output slot 1. Downstream align/shift and add/subtract stages rely on slot 1 having the larger exponent. Registered, single-cycle latency, with a simple valid pipeline flag.

## Interface
Parameters:
- MANT_W, 10: mantissa field width. The MSB is reserved for the integer/hidden-bit position before the binary point.
- EXP_W, 5: exponent field width, unsigned, biased.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operands valid this cycle
- inp1  in  MANT_W  operand 1 mantissa
- sgn1  in  1  operand 1 sign
- exp1  in  EXP_W  operand 1 exponent
- inp2  in  MANT_W  operand 2 mantissa
- sgn2  in  1  operand 2 sign
- exp2  in  EXP_W  operand 2 exponent
- outinp1  out  MANT_W  larger-operand mantissa
- outsign1  out  1  larger-operand sign
- outexp1  out  EXP_W  larger-operand exponent
- outinp2  out  MANT_W  smaller-operand mantissa
- outsgn2  out  1  smaller-operand sign
- outexp2  out  EXP_W  smaller-operand exponent
- exp_diff  out  EXP_W  outexp1 − outexp2, always ≥ 0
- swapped  out  1  1 when the operands were exchanged
- out_valid  out  1  outputs hold a new result

## Operation
- Swap decision `sw`: exp2 > exp1 → sw=1; exp1 > exp2 → sw=0; exponents equal → see Configuration.
- sw=0: slot1 ← {inp1,sgn1,exp1}, slot2 ← {inp2,sgn2,exp2}. sw=1: the reverse.
- Mantissa, sign and exponent move together as one triple; a sign never separates from its operand.
- exp_diff = outexp1 − outexp2, unsigned subtraction on EXP_W bits. No wrap is possible because the larger exponent is always the minuend.
- Sign does not affect ordering; ordering is by magnitude only.
- Mantissa value 0 is not special-cased. Example: inp1=0, exp1=17 still ranks above inp2=32, exp2=11.

## Timing
- All outputs are registered. Result appears on the clock edge after sampling in_valid=1, so latency is 1 cycle. Throughput is 1 operand pair per cycle.
- in_valid=0: data/exp_diff/swapped registers hold their previous values; out_valid goes to 0 on the next edge.
- out_valid is in_valid delayed by one cycle.
- There is no back-pressure; the consumer must accept every out_valid cycle.
- Reset (rst_n=0, asynchronous): all outputs clear to 0 immediately, independent of clk.
- Reset asserted mid-stream: any in-flight pair is discarded.
- First result after reset release needs in_valid=1 on a rising edge with rst_n=1.

## Configuration
- Macro FP_SWAP_MANT_CMP_EN.
- Defined: when exp1==exp2, compare mantissas. inp2 > inp1 → sw=1; otherwise sw=0. With equal exponents and equal mantissas, sw=0.
- Not defined: when exp1==exp2, always sw=0 (original order kept). The mantissa comparator is not synthesized.
- exp_diff is 0 for equal exponents in both builds.

## Test plan
- Basic order: inp1=0,exp1=17,inp2=32,exp2=11, signs 0, in_valid=1 → next cycle outinp1=0, outexp1=17, outinp2=32, outexp2=11, exp_diff=6, swapped=0, out_valid=1.
- Swap: inp1=484,exp1=9,inp2=391,exp2=11 → outinp1=391, outexp1=11, outinp2=484, outexp2=9, exp_diff=2, swapped=1.
- Sign tracking: sgn1=1,exp1=5,inp1=7, sgn2=0,exp2=20,inp2=9 → outsign1=0, outexp1=20, outinp1=9, outsgn2=1, outexp2=5, exp_diff=15, swapped=1.
- Equal-exponent tie: inp1=3,inp2=14, both exp=11.
  - With FP_SWAP_MANT_CMP_EN: outinp1=14, swapped=1.
  - Without it: outinp1=3, swapped=0.
  - inp1=14,inp2=3 gives swapped=0 in both builds.
- Back-to-back streaming: 6 pairs on consecutive cycles, including exp1=29/exp2=27 (inp 897/141 → no swap, exp_diff=2). Results appear in order, one per cycle; out_valid falls the cycle after in_valid falls, and outputs hold their last values.
- Async reset: drive rst_n=0 between clock edges while out_valid=1 → all outputs read 0 before the next edge; they stay 0 until a valid pair is clocked after release.
